// File: rtl/motor_ctrl_pkg.sv
// Shared state encoding for the multi-channel motor controller.
// Codes 5-7 are illegal and force a channel into FAULT.
package motor_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    DN    = 3'd1,
    UP    = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

endpackage

// File: rtl/motor_ch.sv
// One motor channel: limit-switch FSM with a shared travel-timeout / dead-time counter.
// Travel timeout is compiled in only when MOTOR_CTRL_TIMEOUT_EN is defined.
module motor_ch
  import motor_ctrl_pkg::*;
#(
  parameter int DEAD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               activate,
  input  logic               up_limit,
  input  logic               dn_limit,
  input  logic               fault_clr,
  output logic               motor_up,
  output logic               motor_dn,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int TW     = (TO_W > DEAD_W) ? TO_W : DEAD_W;

`ifdef MOTOR_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            expired;

  assign expired = TIMEOUT_EN && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign state   = state_q;

  // The timer counts travel time up in DN/UP and the dead interval down in DEAD.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (activate) begin
          if (up_limit && dn_limit) begin
            state_d = FAULT;
            timer_d = '0;
          end else if (up_limit) begin
            state_d = DN;
            timer_d = '0;
          end else begin
            state_d = UP;
            timer_d = '0;
          end
        end
      end
      DN: begin
        if (dn_limit) begin
          state_d = DEAD;
          timer_d = TW'(DEAD_CYCLES - 1);
        end else if (expired) begin
          state_d = FAULT;
          timer_d = '0;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + TW'(1);
        end
      end
      UP: begin
        if (up_limit) begin
          state_d = DEAD;
          timer_d = TW'(DEAD_CYCLES - 1);
        end else if (expired) begin
          state_d = FAULT;
          timer_d = '0;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + TW'(1);
        end
      end
      DEAD: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = FAULT;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      motor_up <= 1'b0;
      motor_dn <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      motor_up <= (state_d == UP);
      motor_dn <= (state_d == DN);
      fault    <= (state_d == FAULT);
    end
  end

endmodule

// File: rtl/motor_ctrl_multi.sv
// N independent motor channels; this level only slices inputs and packs control_state.
// Travel timeout is enabled by defining MOTOR_CTRL_TIMEOUT_EN.
module motor_ctrl_multi
  import motor_ctrl_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int DEAD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         activate,
  input  logic [NCH-1:0]         up_limit,
  input  logic [NCH-1:0]         dn_limit,
  input  logic [NCH-1:0]         fault_clr,
  output logic [NCH-1:0]         motor_up,
  output logic [NCH-1:0]         motor_dn,
  output logic [NCH-1:0]         fault,
  output logic [STATE_W*NCH-1:0] control_state
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    motor_ch #(
      .DEAD_CYCLES   (DEAD_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .activate (activate[i]),
      .up_limit (up_limit[i]),
      .dn_limit (dn_limit[i]),
      .fault_clr(fault_clr[i]),
      .motor_up (motor_up[i]),
      .motor_dn (motor_dn[i]),
      .fault    (fault[i]),
      .state    (control_state[STATE_W*i +: STATE_W])
    );
  end

endmodule

// File: tb/tb_motor_ctrl_multi.sv
// Scoreboard bench for motor_ctrl_multi; expectations adapt to MOTOR_CTRL_TIMEOUT_EN.
module tb_motor_ctrl_multi;

  localparam int NCH            = 4;
  localparam int DEAD_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DN    = 3'd1;
  localparam logic [2:0] S_UP    = 3'd2;
  localparam logic [2:0] S_DEAD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  typedef struct packed {
    logic [NCH-1:0]   up;
    logic [NCH-1:0]   dn;
    logic [NCH-1:0]   flt;
    logic [3*NCH-1:0] st;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   activate, up_limit, dn_limit, fault_clr;
  logic [NCH-1:0]   motor_up, motor_dn, fault;
  logic [3*NCH-1:0] control_state;

  int    errors = 0;
  int    checks = 0;
  exp_t  sb_q[$];
  string phase = "reset";

  always #5 clk = ~clk;

  motor_ctrl_multi #(
    .NCH           (NCH),
    .DEAD_CYCLES   (DEAD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .activate     (activate),
    .up_limit     (up_limit),
    .dn_limit     (dn_limit),
    .fault_clr    (fault_clr),
    .motor_up     (motor_up),
    .motor_dn     (motor_dn),
    .fault        (fault),
    .control_state(control_state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ch0(input logic u, input logic d, input logic f, input logic [2:0] s);
    exp_t e;
    e        = '0;
    e.up[0]  = u;
    e.dn[0]  = d;
    e.flt[0] = f;
    e.st[2:0] = s;
    return e;
  endfunction

  function automatic exp_t mk(input logic [NCH-1:0] u, input logic [NCH-1:0] d,
                              input logic [2:0] s3, input logic [2:0] s2,
                              input logic [2:0] s1, input logic [2:0] s0);
    exp_t e;
    e.up  = u;
    e.dn  = d;
    e.flt = '0;
    e.st  = {s3, s2, s1, s0};
    return e;
  endfunction

  task automatic compareOutputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput({phase, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      checkOutput({phase, ".motor_up"}, 32'(motor_up), 32'(e.up));
      checkOutput({phase, ".motor_dn"}, 32'(motor_dn), 32'(e.dn));
      checkOutput({phase, ".fault"}, 32'(fault), 32'(e.flt));
      checkOutput({phase, ".state"}, 32'(control_state), 32'(e.st));
      checkOutput({phase, ".exclusive"}, 32'(motor_up & motor_dn), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NCH-1:0] a, input logic [NCH-1:0] ul,
                               input logic [NCH-1:0] dl, input logic [NCH-1:0] fc, input exp_t e);
    @(negedge clk);
    rst       = r;
    activate  = a;
    up_limit  = ul;
    dn_limit  = dl;
    fault_clr = fc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compareOutputs();
  endtask

  initial begin
    rst       = 1'b1;
    activate  = '0;
    up_limit  = '0;
    dn_limit  = '0;
    fault_clr = '0;

    phase = "reset";
    repeat (2) applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0);

    // Upward travel stopped by the limit, dead time, then restart downward.
    phase = "limit_up";
    applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));
    repeat (4) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));
    applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, ch0(0, 0, 0, S_DEAD));
    phase = "dead_hold";
    repeat (DEAD_CYCLES - 1) applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, ch0(0, 0, 0, S_DEAD));
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, ch0(0, 0, 0, S_IDLE));
    phase = "restart_dn";
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, ch0(0, 1, 0, S_DN));
    applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, ch0(0, 0, 0, S_DEAD));
    repeat (DEAD_CYCLES - 1) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_DEAD));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_IDLE));

    // All channels start together with mixed limits and stop at different edges.
    phase = "multi";
    applyStimulus(1'b0, 4'b1111, 4'b1010, 4'b0000, 4'b0000, mk(4'b0101, 4'b1010, S_DN, S_UP, S_DN, S_UP));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, mk(4'b0101, 4'b1010, S_DN, S_UP, S_DN, S_UP));
    applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0010, 4'b0000, mk(4'b0100, 4'b1000, S_DN, S_UP, S_DEAD, S_DEAD));
    applyStimulus(1'b0, 4'b0000, 4'b0101, 4'b1010, 4'b0000, mk(4'b0000, 4'b0000, S_DEAD, S_DEAD, S_DEAD, S_DEAD));
    repeat (DEAD_CYCLES - 2) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                           mk(4'b0000, 4'b0000, S_DEAD, S_DEAD, S_DEAD, S_DEAD));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 4'b0000, S_DEAD, S_DEAD, S_IDLE, S_IDLE));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 4'b0000, S_IDLE, S_IDLE, S_IDLE, S_IDLE));

    // Long downward travel with no limit; a stray fault_clr mid-travel must do nothing.
    phase = "timeout";
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, ch0(0, 1, 0, S_DN));
`ifdef MOTOR_CTRL_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++)
      applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, (i == 3) ? 4'b0001 : 4'b0000, ch0(0, 1, 0, S_DN));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 1, S_FAULT));
    phase = "fault_hold";
    repeat (2) applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 1, S_FAULT));
    phase = "fault_clr";
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, ch0(0, 0, 0, S_IDLE));
`else
    for (int i = 0; i < 2 * TIMEOUT_CYCLES - 1; i++)
      applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, (i == 3) ? 4'b0001 : 4'b0000, ch0(0, 1, 0, S_DN));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, ch0(0, 0, 0, S_DEAD));
    repeat (DEAD_CYCLES - 1) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_DEAD));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_IDLE));
`endif

    phase = "both_limits";
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, ch0(0, 0, 1, S_FAULT));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 1, S_FAULT));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, ch0(0, 0, 0, S_IDLE));

    // Limit arrives on exactly the edge where the timeout would expire.
    phase = "limit_vs_timeout";
    applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));
    repeat (TIMEOUT_CYCLES - 1) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));
    applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, ch0(0, 0, 0, S_DEAD));
    repeat (DEAD_CYCLES - 1) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_DEAD));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_IDLE));

    phase = "reset_mid";
    applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_IDLE));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, ch0(0, 0, 0, S_IDLE));
    applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, ch0(1, 0, 0, S_UP));

    if (sb_q.size() != 0) checkOutput("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
